ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Bitstream writer for the configuration-chain protocol. It accepts configuration words from a host over a valid/ready stream and serialises them, LSB first, onto the `ccff_head` of a tile's configuration chain. It produces a shift enable that gates the chain's `prog_clk`. It sits between the top-level programming interface and the first tile's `ccff_head`, and the last tile's `ccff_tail` returns to it for optional verification.

## Interface
Parameters:
- `CHAIN_LEN`, default 18: total flip-flops in the attached chain (≥1).
- `WORD_W`, default 8: host word width (≥1).

Ports:
- `prog_clk`, in, 1: programming clock.
- `prog_reset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: begin a load; sampled only in IDLE.
- `abort`, in, 1: return to IDLE from any state.
- `bs_data`, in, `WORD_W`: bitstream word; bit 0 is shifted first.
- `bs_valid`, in, 1: `bs_data` is valid.
- `bs_ready`, out, 1: loader accepts the word this cycle.
- `ccff_head`, out, 1: serial data to the chain, registered.
- `shift_en`, out, 1: enables the chain clock edge at the end of this cycle, registered. Drives an external ICG.
- `ccff_tail`, in, 1: serial data returned from the end of the chain.
- `busy`, out, 1: high whenever not in IDLE.
- `done`, out, 1: one-cycle pulse when a load completes.
- `err`, out, 1: sticky verify mismatch; cleared by `start`. Driven 0 when the verify feature is compiled out.

## Operation
- States:
  - IDLE → SHIFT on `start`.
  - SHIFT → VERIFY when `CHAIN_LEN` bits have been shifted. VERIFY exists only with the macro; without it, SHIFT → DONE.
  - VERIFY → DONE when `CHAIN_LEN` bits have been shifted.
  - DONE → IDLE unconditionally.
  - `abort` in any state → IDLE. It takes priority over all other transitions.
- Word buffer: holds one word and a bit index of width `$clog2(WORD_W)`.
  - `bs_ready` = (state is SHIFT or VERIFY) and (buffer empty, or the buffer's last needed bit is being issued this cycle).
  - A transfer occurs when `bs_valid & bs_ready`.
- Issue: each cycle the buffer holds an unshifted bit and the phase bit counter is below `CHAIN_LEN`:
  - register `ccff_head` ← buffer bit and `shift_en` ← 1;
  - increment the index and the counter.
  - Otherwise `shift_en` ← 0. This is a stall, and the chain holds its contents.
- Phase counter: width `$clog2(CHAIN_LEN+1)`. Cleared on entry to SHIFT and to VERIFY.
  - Once the counter reaches `CHAIN_LEN`, the remaining bits of the current word are discarded and the buffer is marked empty.
  - Words per phase = ceil(`CHAIN_LEN`/`WORD_W`).
- Verify phase: the host resends the identical bitstream.
  - The chain then holds bitstream B, so the tail presents B[k] while head presents B[k].
  - In every cycle with `shift_en`=1, compare `ccff_head` with `ccff_tail`. A mismatch sets `err`.
- `done` pulses in DONE. `busy` falls in the same cycle that IDLE is entered.

## Timing
- Reset values: `bs_ready`=0, `ccff_head`=0, `shift_en`=0, `busy`=0, `done`=0, `err`=0. State=IDLE, counters and buffer cleared.
- Start latency:
  - `start` sampled at edge 0 moves the state to SHIFT, and `bs_ready` is high from cycle 1.
  - A word accepted at edge n gives its first `shift_en`=1 in cycle n+1.
- Throughput is one bit per cycle with back-to-back words; there are no bubbles at word boundaries.
- Simultaneous `start` and `abort` in IDLE: stay in IDLE.
- `abort`: `shift_en` is 0 from the next cycle. A partial word is discarded. Chain contents are undefined, `done` is not pulsed, and `err` is held.
- Reset mid-load has the same effect on the chain as `abort`, plus all outputs take their reset values.
- Bits of the final word above `CHAIN_LEN mod WORD_W` are never presented on `ccff_head`.
- If `bs_valid` is low mid-word, nothing stalls until the buffer empties.

## Configuration
- `CCFF_LOADER_VERIFY_EN` defined:
  - the VERIFY state, the comparator and the `err` logic are built;
  - one load consumes 2×ceil(`CHAIN_LEN`/`WORD_W`) words.
- Not defined:
  - SHIFT → DONE directly, and `err` is tied 0;
  - `ccff_tail` is unused; the port remains so the instance is identical in both builds.

## Structure
- Package `ccff_loader_pkg` holds:
  - the state enum (IDLE, SHIFT, VERIFY, DONE);
  - a `words_per_pass(CHAIN_LEN, WORD_W)` function;
  - the counter width constant functions.
- Sub-module `ccff_loader_serializer` holds the word buffer, the bit index, `bs_ready` generation and the issue logic. The top level holds the FSM, the phase counter and verify.

## Test plan
- `CHAIN_LEN`=18, `WORD_W`=8, words 0xA5, 0x3C, 0x02 sent continuously:
  - exactly 18 consecutive `shift_en` cycles;
  - head sequence = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1;
  - word 0x02's bits 2–7 are never issued;
  - `done` pulses once.
- Same load with `bs_valid` dropped for 3 cycles after word 1: `shift_en` is low for exactly 3 cycles after bit 15, the head sequence is unchanged, and the total is still 18 shifts.
- Verify build, 18-bit chain model, bitstream sent twice: `err`=0 and `done` pulses. Corrupting bit 9 of the second pass gives `err`=1 from the cycle after bit 9, still set after `done`.
- `abort` asserted after bit 7: `shift_en`=0 on the next cycle, state IDLE, no `done`. A following `start` reloads all 18 bits correctly.
- `prog_reset_n` asserted mid-word asynchronously: all outputs go to 0 immediately. After release, a new `start` completes a normal load.
- `CHAIN_LEN`=8, `WORD_W`=8: one word per pass and 8 shifts.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ccff_loader_pkg
// Description : Shared types and constant helpers for the configuration-chain
//               bitstream loader (state encoding, counter widths, words per
//               chain pass).
// Revision    : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    // Loader FSM states. VERIFY is only reachable when the read-back
    // check is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } ccff_state_e;

    // Host words needed to cover the whole chain once.
    function automatic int words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Phase counter must be able to hold the value chain_len itself.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    // Bit index into one host word; at least one bit wide so a 1-bit word
    // still has a legal index register.
    function automatic int idx_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage : ccff_loader_pkg
`default_nettype wire

// File: rtl/ccff_loader_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ccff_loader_serializer
// Description : One-word buffer that turns host words into a serial bit
//               stream, LSB first, with a registered head bit and a
//               registered shift enable for the chain clock gate.
// Ports       : clk, rst_n         - programming clock, async active-low reset
//               i_enable           - a phase is running and still needs bits
//               i_phase_last       - the bit issued this cycle ends the phase
//               i_bs_data/valid    - host word stream
//               o_bs_ready         - host word accepted this cycle
//               o_issue            - a bit is issued this cycle
//               o_ccff_head        - registered serial data to the chain
//               o_shift_en         - registered chain clock enable
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_loader_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int IDX_W  = idx_width(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic              i_phase_last,
    input  logic [WORD_W-1:0] i_bs_data,
    input  logic              i_bs_valid,
    output logic              o_bs_ready,
    output logic              o_issue,
    output logic              o_ccff_head,
    output logic              o_shift_en
);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic              r_full;
    logic              r_ccff_head;
    logic              r_shift_en;

    logic w_last_bit;
    logic w_word_done;
    logic w_xfer;

    assign w_last_bit = (r_idx == c_idx_last);
    assign o_issue    = i_enable & r_full;

    // The buffer empties after the word's top bit or after the phase's final
    // bit; in the latter case any higher bits of the word are dropped.
    assign w_word_done = o_issue & (w_last_bit | i_phase_last);

    // Refill in the same cycle the last bit leaves, so consecutive words
    // stream without a bubble. No refill on the phase's final bit: that word
    // would belong to the next phase or the next load.
    assign o_bs_ready = i_enable & (~r_full | (o_issue & w_last_bit & ~i_phase_last));
    assign w_xfer     = i_bs_valid & o_bs_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (!i_enable) begin
            // Phase over, aborted or idle: discard whatever is left.
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_xfer) begin
            r_buf  <= i_bs_data;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (w_word_done) begin
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (o_issue) begin
            r_idx  <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccff_head <= 1'b0;
            r_shift_en  <= 1'b0;
        end else begin
            r_shift_en <= o_issue;
            if (o_issue) begin
                r_ccff_head <= r_buf[r_idx];
            end
        end
    end

    assign o_ccff_head = r_ccff_head;
    assign o_shift_en  = r_shift_en;

endmodule : ccff_loader_serializer
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Configuration-chain bitstream writer. Accepts host words on a
//               valid/ready stream and shifts CHAIN_LEN bits, LSB first, into
//               the chain head, gating prog_clk through shift_en. With the
//               macro CCFF_LOADER_VERIFY_EN defined, a second pass of the same
//               bitstream is shifted in while the chain tail is compared
//               against the head; any difference sets the sticky err flag.
// Ports       : prog_clk, prog_reset_n   - clock, async active-low reset
//               start, abort             - begin a load / return to idle
//               bs_data, bs_valid,
//               bs_ready                 - host word stream
//               ccff_head, shift_en      - chain data and clock enable
//               ccff_tail                - chain read-back (verify only)
//               busy, done, err          - status
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 18,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_cnt_w = cnt_width(CHAIN_LEN);
    localparam int c_idx_w = idx_width(WORD_W);
    localparam logic [c_cnt_w-1:0] c_chain_len  = c_cnt_w'(CHAIN_LEN);
    localparam logic [c_cnt_w-1:0] c_chain_last = c_cnt_w'(CHAIN_LEN - 1);

    ccff_state_e        r_state;
    ccff_state_e        w_state_next;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_active;
    logic w_phase_full;
    logic w_phase_last;
    logic w_enable;
    logic w_phase_entry;
    logic w_issue;

    assign w_active     = (r_state == ST_SHIFT) || (r_state == ST_VERIFY);
    assign w_phase_full = (r_cnt == c_chain_len);
    assign w_phase_last = (r_cnt == c_chain_last);
    // Abort also blocks issue, so shift_en is low from the following cycle.
    assign w_enable     = w_active & ~abort & ~w_phase_full;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_phase_full) begin
`ifdef CCFF_LOADER_VERIFY_EN
                    w_state_next = ST_VERIFY;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
            ST_VERIFY: begin
                if (w_phase_full) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Phase bit counter: restarts on entry to each shifting phase.
    // ------------------------------------------------------------------
    assign w_phase_entry = (w_state_next != r_state) &&
                           ((w_state_next == ST_SHIFT) || (w_state_next == ST_VERIFY));

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_cnt <= '0;
        end else if (w_phase_entry || !w_active) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Word buffer and bit issue
    // ------------------------------------------------------------------
    ccff_loader_serializer #(
        .WORD_W (WORD_W),
        .IDX_W  (c_idx_w)
    ) u_serializer (
        .clk          (prog_clk),
        .rst_n        (prog_reset_n),
        .i_enable     (w_enable),
        .i_phase_last (w_phase_last),
        .i_bs_data    (bs_data),
        .i_bs_valid   (bs_valid),
        .o_bs_ready   (bs_ready),
        .o_issue      (w_issue),
        .o_ccff_head  (ccff_head),
        .o_shift_en   (shift_en)
    );

    // ------------------------------------------------------------------
    // Read-back check
    // ------------------------------------------------------------------
`ifdef CCFF_LOADER_VERIFY_EN
    logic r_err;

    // During the second pass the chain already holds the first pass, so the
    // tail presents the same bit index the head is presenting.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start && !abort) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_VERIFY) && shift_en && (ccff_head != ccff_tail)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign err           = 1'b0;
`endif

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule : ccff_chain_loader
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ccff_chain_loader
// Description : Directed self-checking bench for ccff_chain_loader with an
//               18-bit and an 8-bit chain model on the head/tail ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;

    localparam int CL  = 18;
    localparam int WW  = 8;
    localparam int WPP = 3;   // ceil(18/8)
    localparam int CL8 = 8;
`ifdef CCFF_LOADER_VERIFY_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          bs_valid = 1'b0;
    logic [WW-1:0] bs_data  = '0;
    logic          bs_ready, ccff_head, shift_en, busy, done, err, ccff_tail;
    logic [CL-1:0] chain    = '0;

    logic          start8   = 1'b0;
    logic          valid8   = 1'b0;
    logic [7:0]    data8    = '0;
    logic          ready8, head8, sen8, busy8, done8, err8, tail8;
    logic [CL8-1:0] chain8  = '0;

    always #5 clk = ~clk;

    // Chain models: shift on the edge that ends a shift_en cycle.
    always @(posedge clk) if (shift_en) chain  <= {chain[CL-2:0], ccff_head};
    always @(posedge clk) if (sen8)     chain8 <= {chain8[CL8-2:0], head8};
    assign ccff_tail = chain[CL-1];
    assign tail8     = chain8[CL8-1];

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
        .prog_clk (clk), .prog_reset_n (rst_n), .start (start), .abort (abort),
        .bs_data (bs_data), .bs_valid (bs_valid), .bs_ready (bs_ready),
        .ccff_head (ccff_head), .shift_en (shift_en), .ccff_tail (ccff_tail),
        .busy (busy), .done (done), .err (err)
    );

    ccff_chain_loader #(.CHAIN_LEN(CL8), .WORD_W(8)) u_dut8 (
        .prog_clk (clk), .prog_reset_n (rst_n), .start (start8), .abort (1'b0),
        .bs_data (data8), .bs_valid (valid8), .bs_ready (ready8),
        .ccff_head (head8), .shift_en (sen8), .ccff_tail (tail8),
        .busy (busy8), .done (done8), .err (err8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Model: the bitstream of each pass is the pass's words, LSB first,
    // truncated to CL bits. The head during the n-th shift cycle must be
    // bit n of that stream; err must rise the cycle after a second-pass
    // bit differs from the first-pass bit at the same position.
    // ---------------------------------------------------------------
    logic [7:0]  ld_words [0:5];
    bit          mon_on   = 1'b0;
    int          shifts, dones, accepted, gap;
    logic        err_exp  = 1'b0;
    logic [35:0] head_log;
    int          m_p, m_k;
    logic        m_b;

    function automatic logic stream_bit(input int p, input int k);
        logic [7:0] w;
        w = ld_words[p*WPP + k/WW];
        return w[k%WW];
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (bs_valid && bs_ready) accepted++;
            check("err", err, err_exp);
            if (shift_en) begin
                m_p = shifts / CL;
                m_k = shifts % CL;
                if (m_p < PASSES) begin
                    m_b = stream_bit(m_p, m_k);
                    check("head", ccff_head, m_b);
                    head_log[shifts] = ccff_head;
                    if (m_p == 1 && m_b != stream_bit(0, m_k)) err_exp = 1'b1;
                end
                shifts++;
            end else if (shifts % CL != 0) begin
                gap++;
            end
            if (done) dones++;
        end
    end

    task automatic set_words(input logic [7:0] a0, a1, a2, b0, b1, b2);
        ld_words[0] = a0; ld_words[1] = a1; ld_words[2] = a2;
        ld_words[3] = b0; ld_words[4] = b1; ld_words[5] = b2;
    endtask

    // Host driver. stall_at: word index held back for stall_len ready cycles.
    // abort_after / reset_after: shift count that triggers abort / reset.
    task automatic run_load(input int nwords, input int stall_at, input int stall_len,
                            input int abort_after, input int reset_after, output bit fin);
        int  stall_left;
        bit  aborted;
        bit  was_reset;
        shifts = 0; dones = 0; accepted = 0; gap = 0; head_log = '0;
        stall_left = stall_len; aborted = 1'b0; was_reset = 1'b0; fin = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; err_exp = 1'b0; mon_on = 1'b1;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            abort    = (abort_after > 0) && !aborted && (shifts >= abort_after);
            if (abort) aborted = 1'b1;
            bs_valid = !aborted && (accepted < nwords) && !(accepted == stall_at && stall_left > 0);
            bs_data  = ld_words[(accepted < 6) ? accepted : 0];
            @(negedge clk); #1;
            if (cyc == 0) check("ready_after_start", bs_ready, 1);
            if (!bs_valid && accepted == stall_at && stall_left > 0 && bs_ready) stall_left--;
            if (aborted && !abort) begin
                check("abort_shift_en", shift_en, 0);
                check("abort_busy", busy, 0);
                fin = 1'b1;
            end
            if (reset_after > 0 && shifts >= reset_after) begin
                check("busy_before_reset", busy, 1);
                #1 rst_n = 1'b0;
                #1;
                check("rst_ready", bs_ready, 0);
                check("rst_head", ccff_head, 0);
                check("rst_shift_en", shift_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                mon_on = 1'b0; was_reset = 1'b1; fin = 1'b1;
            end
            if (dones > 0) fin = 1'b1;
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        bs_valid = 1'b0; abort = 1'b0;
        if (!was_reset) repeat (3) @(negedge clk);
        mon_on = 1'b0;
    endtask

    bit fin;
    int s8, d8, a8;
    logic [7:0] log8;
    logic [7:0] ref8;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bs_ready, 0);
        check("reset_head", ccff_head, 0);
        check("reset_shift_en", shift_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Continuous load: 18 back-to-back shifts
        set_words(8'hA5, 8'h3C, 8'h02, 8'hA5, 8'h3C, 8'h02);
        run_load(PASSES*WPP, -1, 0, 0, 0, fin);
        check("t1_finished", fin, 1);
        check("t1_shifts", shifts, PASSES*CL);
        check("t1_head_seq", head_log[17:0], 18'h23CA5);
        check("t1_gap", gap, 0);
        check("t1_done_count", dones, 1);
        check("t1_words", accepted, PASSES*WPP);
        check("t1_busy_after", busy, 0);

        // Host stalls 3 cycles before word 2
        run_load(PASSES*WPP, 2, 3, 0, 0, fin);
        check("t2_finished", fin, 1);
        check("t2_shifts", shifts, PASSES*CL);
        check("t2_head_seq", head_log[17:0], 18'h23CA5);
        check("t2_gap", gap, 3);
        check("t2_done_count", dones, 1);

`ifdef CCFF_LOADER_VERIFY_EN
        // Second pass with bit 9 flipped
        set_words(8'hA5, 8'h3C, 8'h02, 8'hA5, 8'h3E, 8'h02);
        run_load(2*WPP, -1, 0, 0, 0, fin);
        check("t3_finished", fin, 1);
        check("t3_done_count", dones, 1);
        check("t3_err_sticky", err, 1);
        set_words(8'hA5, 8'h3C, 8'h02, 8'hA5, 8'h3C, 8'h02);
`endif

        // Abort after bit 7
        run_load(PASSES*WPP, -1, 0, 8, 0, fin);
        check("t4_finished", fin, 1);
        check("t4_no_done", dones, 0);
        check("t4_busy", busy, 0);

        // Reload after abort
        run_load(PASSES*WPP, -1, 0, 0, 0, fin);
        check("t5_finished", fin, 1);
        check("t5_shifts", shifts, PASSES*CL);
        check("t5_head_seq", head_log[17:0], 18'h23CA5);
        check("t5_done_count", dones, 1);

        // Asynchronous reset mid-word, then a normal load
        run_load(PASSES*WPP, -1, 0, 0, 3, fin);
        @(posedge clk); #1 rst_n = 1'b1;
        run_load(PASSES*WPP, -1, 0, 0, 0, fin);
        check("t7_finished", fin, 1);
        check("t7_shifts", shifts, PASSES*CL);
        check("t7_head_seq", head_log[17:0], 18'h23CA5);
        check("t7_done_count", dones, 1);

        // 8-bit chain, 8-bit words: one word per pass
        s8 = 0; d8 = 0; a8 = 0; log8 = '0; ref8 = 8'h5A; fin = 1'b0;
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            valid8 = (a8 < PASSES);
            data8  = ref8;
            @(negedge clk);
            if (valid8 && ready8) a8++;
            check("err8", err8, 0);
            if (sen8) begin
                check("head8", head8, ref8[s8%8]);
                if (s8 < 8) log8[s8] = head8;
                s8++;
            end
            if (done8) begin
                d8++;
                fin = 1'b1;
            end
            @(posedge clk); #1;
        end
        valid8 = 1'b0;
        check("t8_finished", fin, 1);
        check("t8_shifts", s8, CL8*PASSES);
        check("t8_words", a8, PASSES);
        check("t8_done_count", d8, 1);
        check("t8_head_seq", log8, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ccff_chain_loader
`default_nettype wire
